// File: rtl/mux3_if.sv
// mux3_if: bundles the data, select and enable inputs of the 3-way mux together
// with its combinational and registered results.
//   master : drives i_d0/i_d1/i_d2, i_sel, i_en; observes all o_* results
//   slave  : the mux itself; consumes i_* and produces o_y, o_y_q,
//            o_sel_rsvd, o_sel_rsvd_sticky
interface mux3_if #(
  parameter int P_DATA_WIDTH = 32
);
  logic [P_DATA_WIDTH-1:0] i_d0;
  logic [P_DATA_WIDTH-1:0] i_d1;
  logic [P_DATA_WIDTH-1:0] i_d2;
  logic [1:0]              i_sel;
  logic                    i_en;
  logic [P_DATA_WIDTH-1:0] o_y;
  logic [P_DATA_WIDTH-1:0] o_y_q;
  logic                    o_sel_rsvd;
  logic                    o_sel_rsvd_sticky;

  modport master (
    output i_d0, i_d1, i_d2, i_sel, i_en,
    input  o_y, o_y_q, o_sel_rsvd, o_sel_rsvd_sticky
  );

  modport slave (
    input  i_d0, i_d1, i_d2, i_sel, i_en,
    output o_y, o_y_q, o_sel_rsvd, o_sel_rsvd_sticky
  );
endinterface

// File: rtl/mux3.sv
// mux3: 3-way data multiplexer with a registered copy of its result and a
// sticky flag that records any use of the reserved select code 2'b11.
//   i_clk    : single clock, all state changes on the rising edge
//   i_rst_n  : synchronous active-low reset (clears o_y_q and the sticky flag)
//   bus      : mux3_if slave modport
//     i_d0/i_d1/i_d2 : data inputs (select 00 / 01 / 1x)
//     i_sel          : select code, bit 1 has priority over bit 0
//     i_en           : load enable for o_y_q
//     o_y            : combinational mux result
//     o_y_q          : o_y registered when i_en is high
//     o_sel_rsvd     : combinational, high when i_sel == 2'b11
//     o_sel_rsvd_sticky : set on any edge that samples i_sel == 2'b11
module mux3 #(
  parameter int P_DATA_WIDTH = 32
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  mux3_if.slave bus
);

  logic [P_DATA_WIDTH-1:0] y_next;
  logic [P_DATA_WIDTH-1:0] y_q_reg;
  logic                    sticky_reg;
  logic                    rsvd_next;

  // Per-bit selection. Bit 1 of the select is tested first so that an
  // unknown bit 0 still resolves to i_d2 whenever bit 1 is high.
  for (genvar gi = 0; gi < P_DATA_WIDTH; gi++) begin : g_bit
    assign y_next[gi] = bus.i_sel[1] ? bus.i_d2[gi]
                      : (bus.i_sel[0] ? bus.i_d1[gi] : bus.i_d0[gi]);
  end

  assign rsvd_next = (bus.i_sel == 2'b11);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      y_q_reg    <= '0;
      sticky_reg <= 1'b0;
    end else begin
      if (bus.i_en) begin
        y_q_reg <= y_next;
      end
      // The reserved-code latch ignores the enable: any sampled 2'b11 counts.
      if (rsvd_next) begin
        sticky_reg <= 1'b1;
      end
    end
  end

  assign bus.o_y               = y_next;
  assign bus.o_sel_rsvd        = rsvd_next;
  assign bus.o_y_q             = y_q_reg;
  assign bus.o_sel_rsvd_sticky = sticky_reg;

endmodule

// File: tb/tb_mux3.sv
module tb_mux3;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // Reference state of the registered outputs.
  logic [W-1:0] m_q;
  logic         m_sticky;

  mux3_if #(.P_DATA_WIDTH(W)) bus ();

  mux3 #(.P_DATA_WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 1 ms");
    $fatal(1, "watchdog");
  end

  // Select codes index a table of the inputs; 10 and 11 both name i_d2.
  function automatic logic [W-1:0] ref_y(input logic [1:0] sel,
                                         input logic [W-1:0] d0,
                                         input logic [W-1:0] d1,
                                         input logic [W-1:0] d2);
    logic [W-1:0] tbl [4];
    tbl[0] = d0; tbl[1] = d1; tbl[2] = d2; tbl[3] = d2;
    return tbl[sel];
  endfunction

  task automatic drive(input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [1:0] sel,
                       input logic en);
    bus.i_d0 = d0; bus.i_d1 = d1; bus.i_d2 = d2; bus.i_sel = sel; bus.i_en = en;
    #1;
  endtask

  // Advance one clock edge, updating the reference registers from the
  // inputs present at that edge; returns 1 time unit after the edge.
  task automatic tick();
    if (!rst_n) begin
      m_q = '0;
      m_sticky = 1'b0;
    end else begin
      if (bus.i_en) m_q = ref_y(bus.i_sel, bus.i_d0, bus.i_d1, bus.i_d2);
      if (bus.i_sel == 2'b11) m_sticky = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(32'h0BAD_F00D, 32'h1111_2222, 32'hCAFE_BABE, 2'b11, 1'b1);
    tick();
    tick();
    checks++;
    if (bus.o_y_q !== 32'h0) begin
      failures++;
      $display("FAIL reset_y_q: got %h required %h", bus.o_y_q, 32'h0);
    end
    checks++;
    if (bus.o_sel_rsvd_sticky !== 1'b0) begin
      failures++;
      $display("FAIL reset_sticky: got %b required 0", bus.o_sel_rsvd_sticky);
    end
    checks++;
    if (bus.o_y !== 32'hCAFE_BABE || bus.o_sel_rsvd !== 1'b1) begin
      failures++;
      $display("FAIL reset_comb: got y=%h rsvd=%b required y=CAFEBABE rsvd=1", bus.o_y, bus.o_sel_rsvd);
    end
    $display("test_reset: y_q=%h sticky=%b", bus.o_y_q, bus.o_sel_rsvd_sticky);
    rst_n = 1'b1;
  endtask

  task automatic test_select();
    logic [W-1:0] exp_a [3];
    logic [1:0]   sel_a [3];
    logic [W-1:0] exp_b [3];
    logic [1:0]   sel_b [3];
    exp_a = '{32'hAAAA_AAAA, 32'h5555_5555, 32'hBBBB_BBBB};
    sel_a = '{2'b00, 2'b01, 2'b10};
    exp_b = '{32'h1234_5678, 32'hA76A_BC43, 32'h8765_4321};
    sel_b = '{2'b00, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) begin
      drive(32'hAAAA_AAAA, 32'h5555_5555, 32'hBBBB_BBBB, sel_a[i], 1'b0);
      checks++;
      if (bus.o_y !== exp_a[i] || bus.o_sel_rsvd !== 1'b0) begin
        failures++;
        $display("FAIL select_a sel=%b: got y=%h rsvd=%b required y=%h rsvd=0", sel_a[i], bus.o_y, bus.o_sel_rsvd, exp_a[i]);
      end
      $display("test_select a: sel=%b y=%h", sel_a[i], bus.o_y);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(32'h1234_5678, 32'h8765_4321, 32'hA76A_BC43, sel_b[i], 1'b0);
      checks++;
      if (bus.o_y !== exp_b[i]) begin
        failures++;
        $display("FAIL select_b sel=%b: got y=%h required %h", sel_b[i], bus.o_y, exp_b[i]);
      end
      $display("test_select b: sel=%b y=%h", sel_b[i], bus.o_y);
      tick();
    end
  endtask

  task automatic test_rsvd();
    drive(32'h1234_5678, 32'h8765_4321, 32'hA76A_BC43, 2'b11, 1'b0);
    checks++;
    if (bus.o_y !== 32'hA76A_BC43 || bus.o_sel_rsvd !== 1'b1) begin
      failures++;
      $display("FAIL rsvd_comb: got y=%h rsvd=%b required y=A76ABC43 rsvd=1", bus.o_y, bus.o_sel_rsvd);
    end
    checks++;
    if (bus.o_sel_rsvd_sticky !== 1'b0) begin
      failures++;
      $display("FAIL rsvd_sticky_pre: got %b required 0", bus.o_sel_rsvd_sticky);
    end
    tick();
    checks++;
    if (bus.o_sel_rsvd_sticky !== 1'b1) begin
      failures++;
      $display("FAIL rsvd_sticky_set: got %b required 1", bus.o_sel_rsvd_sticky);
    end
    drive(32'h1234_5678, 32'h8765_4321, 32'hA76A_BC43, 2'b00, 1'b0);
    tick();
    checks++;
    if (bus.o_sel_rsvd_sticky !== 1'b1 || bus.o_sel_rsvd !== 1'b0) begin
      failures++;
      $display("FAIL rsvd_sticky_hold: got sticky=%b rsvd=%b required sticky=1 rsvd=0", bus.o_sel_rsvd_sticky, bus.o_sel_rsvd);
    end
    $display("test_rsvd: sticky=%b", bus.o_sel_rsvd_sticky);
  endtask

  task automatic test_enable_hold();
    drive(32'h0000_0001, 32'h5555_5555, 32'h0000_0002, 2'b01, 1'b1);
    tick();
    checks++;
    if (bus.o_y_q !== 32'h5555_5555) begin
      failures++;
      $display("FAIL enable_load: got %h required 55555555", bus.o_y_q);
    end
    drive(32'hDEAD_BEEF, 32'h5555_5555, 32'h0000_0002, 2'b00, 1'b0);
    tick();
    tick();
    checks++;
    if (bus.o_y_q !== 32'h5555_5555 || bus.o_y !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL enable_hold: got y_q=%h y=%h required y_q=55555555 y=DEADBEEF", bus.o_y_q, bus.o_y);
    end
    $display("test_enable_hold: y_q=%h y=%h", bus.o_y_q, bus.o_y);
  endtask

  task automatic test_reset_override();
    // Sticky is 1 from test_rsvd; reset must clear both registers even with i_en=1.
    rst_n = 1'b0;
    drive(32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 2'b01, 1'b1);
    tick();
    checks++;
    if (bus.o_y_q !== 32'h0 || bus.o_sel_rsvd_sticky !== 1'b0) begin
      failures++;
      $display("FAIL reset_override: got y_q=%h sticky=%b required y_q=00000000 sticky=0", bus.o_y_q, bus.o_sel_rsvd_sticky);
    end
    drive(32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 2'b10, 1'b1);
    checks++;
    if (bus.o_y !== 32'h3C3C_3C3C) begin
      failures++;
      $display("FAIL reset_comb_track: got %h required 3C3C3C3C", bus.o_y);
    end
    $display("test_reset_override: y_q=%h sticky=%b y=%h", bus.o_y_q, bus.o_sel_rsvd_sticky, bus.o_y);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [W-1:0] d0, d1, d2, ey;
    logic [1:0]   sel;
    logic         en;
    int           local_fail;
    local_fail = 0;
    for (int i = 0; i < 1000; i++) begin
      d0  = $urandom;
      d1  = $urandom;
      d2  = $urandom;
      sel = 2'($urandom_range(0, 3));
      en  = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 49) != 0);
      drive(d0, d1, d2, sel, en);
      ey = ref_y(sel, d0, d1, d2);
      checks++;
      if (bus.o_y !== ey || bus.o_sel_rsvd !== (sel == 2'b11)) begin
        failures++; local_fail++;
        $display("FAIL rand_comb #%0d sel=%b: got y=%h rsvd=%b required y=%h rsvd=%b", i, sel, bus.o_y, bus.o_sel_rsvd, ey, (sel == 2'b11));
      end
      tick();
      checks++;
      if (bus.o_y_q !== m_q || bus.o_sel_rsvd_sticky !== m_sticky) begin
        failures++; local_fail++;
        $display("FAIL rand_reg #%0d: got y_q=%h sticky=%b required y_q=%h sticky=%b", i, bus.o_y_q, bus.o_sel_rsvd_sticky, m_q, m_sticky);
      end
    end
    rst_n = 1'b1;
    $display("test_random: 1000 vectors, %0d mismatching", local_fail);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_q = 'x;
    m_sticky = 1'bx;
    rst_n = 1'b1;
    bus.i_d0 = '0; bus.i_d1 = '0; bus.i_d2 = '0; bus.i_sel = 2'b00; bus.i_en = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_select();
    test_rsvd();
    test_enable_hold();
    test_reset_override();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux3.md
MUX3 -- requirements
Module: mux3

Interface
REQ-001 Parameter P_DATA_WIDTH, default 32, width of every data port and of the registered output.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low; sampled only on i_clk rising edge.
REQ-004 i_d0  input  P_DATA_WIDTH  data input, selected when i_sel=00.
REQ-005 i_d1  input  P_DATA_WIDTH  data input, selected when i_sel=01.
REQ-006 i_d2  input  P_DATA_WIDTH  data input, selected when i_sel=10 or 11.
REQ-007 i_sel  input  2  select code.
REQ-008 i_en  input  1  load enable for registered output.
REQ-009 o_y  output  P_DATA_WIDTH  combinational mux result.
REQ-010 o_y_q  output  P_DATA_WIDTH  registered copy of o_y.
REQ-011 o_sel_rsvd  output  1  combinational flag, high when i_sel=11.
REQ-012 o_sel_rsvd_sticky  output  1  registered sticky flag, set once i_sel=11 is sampled.

Function
REQ-013 o_y SHALL equal i_d0 when i_sel=00, i_d1 when i_sel=01, i_d2 when i_sel[1]=1 (10 and 11).
REQ-014 o_y SHALL be purely combinational: zero cycles latency, independent of i_clk, i_rst_n, i_en.
REQ-015 o_y SHALL propagate all P_DATA_WIDTH bits unmodified; no bit masking, extension or truncation.
REQ-016 i_sel bit 1 SHALL take priority over bit 0.
REQ-017 If i_sel contains X/Z, o_y SHALL follow the resolved case with i_d2 when i_sel[1]=1; otherwise simulation X is acceptable.
REQ-018 On rising edge with i_rst_n=1 and i_en=1, o_y_q SHALL load current o_y (1-cycle latency).
REQ-019 On rising edge with i_rst_n=1 and i_en=0, o_y_q SHALL hold.
REQ-020 o_sel_rsvd SHALL be high exactly when i_sel=11, combinationally; o_y still equals i_d2.
REQ-021 On rising edge with i_rst_n=1 and i_sel=11, o_sel_rsvd_sticky SHALL set to 1 regardless of i_en; it stays 1 until reset.
REQ-022 Selection changes SHALL not affect o_y_q except through the next enabled edge.

Reset
REQ-023 On rising edge with i_rst_n=0: o_y_q SHALL become 0 and o_sel_rsvd_sticky SHALL become 0; reset overrides i_en and i_sel.
REQ-024 Reset SHALL not affect o_y or o_sel_rsvd, which remain combinational during reset.
REQ-025 Before the first reset edge, registered outputs are undefined; the bench applies reset at least one cycle first.

Verification
REQ-026 d0=AAAAAAAA, d1=55555555, d2=BBBBBBBB; sel=0,1,2 in turn, 10 ns each -> o_y=AAAAAAAA, 55555555, BBBBBBBB.
REQ-027 d0=12345678, d1=87654321, d2=A76ABC43; sel=0,2,1 -> o_y=12345678, A76ABC43, 87654321.
REQ-028 sel=11, d2=A76ABC43 -> o_y=A76ABC43, o_sel_rsvd=1; after next edge o_sel_rsvd_sticky=1; later sel=00 keeps sticky=1.
REQ-029 i_en=1, sel=01, d1=55555555, one edge -> o_y_q=55555555; then i_en=0, sel=00 -> o_y_q stays 55555555 while o_y=d0.
REQ-030 i_rst_n=0 for one edge with i_en=1, sticky=1 -> o_y_q=00000000, sticky=0, o_y still tracks inputs.
REQ-031 Random sweep, 1000 vectors of all select codes and random data -> o_y matches REQ-013 and o_y_q matches prior-cycle o_y when enabled.
